frame_op_sequencer: RTL and testbench

Command-driven initiator for the frame-pointer register write interface. It executes the ENTER and LEAVE stack-frame operations. For each operation it performs the stack memory access, then drives the 4-bit read_or_write code and the write data into the ebp and esp registers for exactly one cycle. It sits between the instruction decoder (command side) and the register/memory blocks.

---
 rtl/frame_op_sequencer_if.sv | 37 +++
 rtl/frame_op_sequencer.sv | 161 ++++++++++++++++
 tb/tb_frame_op_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/frame_op_sequencer_if.sv
// Signal bundle between the frame-op sequencer and its environment:
// the decoder command port, the ebp/esp register write ports and the stack memory port.
interface frame_op_sequencer_if #(
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [DATA_W-1:0] ebp_in;
    logic [DATA_W-1:0] esp_in;
    logic [3:0]        ebp_rw;
    logic [DATA_W-1:0] ebp_wdata;
    logic [3:0]        esp_rw;
    logic [DATA_W-1:0] esp_wdata;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              done;
    logic              err;

    // The sequencer side.
    modport master (
        input  cmd_valid, cmd_op, ebp_in, esp_in, mem_ack, mem_rdata,
        output cmd_ready, ebp_rw, ebp_wdata, esp_rw, esp_wdata,
        output mem_req, mem_we, mem_addr, mem_wdata, done, err
    );

    // The decoder / register file / memory side.
    modport slave (
        output cmd_valid, cmd_op, ebp_in, esp_in, mem_ack, mem_rdata,
        input  cmd_ready, ebp_rw, ebp_wdata, esp_rw, esp_wdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, done, err
    );
endinterface

// File: rtl/frame_op_sequencer.sv
// ENTER/LEAVE sequencer: one stack memory access, then a single-cycle write of ebp and esp.
// All outputs are registered; the *_d values are the outputs for the next cycle.
module frame_op_sequencer #(
    parameter int              DATA_W     = 32,
    parameter int              STACK_STEP = 4,
    parameter int              TIMEOUT    = 15,
    parameter logic [3:0]      WR_CODE    = 4'h2
) (
    input logic                  clock,
    input logic                  reset,
    frame_op_sequencer_if.master bus
);
    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [DATA_W-1:0] STEP     = DATA_W'(STACK_STEP);
    localparam logic [1:0]        OP_ENTER = 2'b01;
    localparam logic [1:0]        OP_LEAVE = 2'b10;

    typedef enum logic [1:0] {IDLE, MEM, WB, ERR} state_e;

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [DATA_W-1:0] ebp_q, ebp_d;
    logic [DATA_W-1:0] esp_q, esp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]        ebp_rw_q, ebp_rw_d;
    logic [3:0]        esp_rw_q, esp_rw_d;
    logic [DATA_W-1:0] ebp_wdata_q, ebp_wdata_d;
    logic [DATA_W-1:0] esp_wdata_q, esp_wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        ebp_d       = ebp_q;
        esp_d       = esp_q;
        cnt_d       = cnt_q;
        cmd_ready_d = cmd_ready_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ebp_wdata_d = ebp_wdata_q;
        esp_wdata_d = esp_wdata_q;
        ebp_rw_d    = 4'h0;
        esp_rw_d    = 4'h0;
        done_d      = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    op_d        = bus.cmd_op;
                    ebp_d       = bus.ebp_in;
                    esp_d       = bus.esp_in;
                    cnt_d       = '0;
                    cmd_ready_d = 1'b0;
                    if (bus.cmd_op == OP_ENTER || bus.cmd_op == OP_LEAVE) begin
                        state_d     = MEM;
                        mem_req_d   = 1'b1;
                        mem_we_d    = (bus.cmd_op == OP_ENTER);
                        mem_addr_d  = (bus.cmd_op == OP_ENTER) ? bus.esp_in - STEP : bus.ebp_in;
                        mem_wdata_d = bus.ebp_in;
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            MEM: begin
                if (bus.mem_ack) begin
                    state_d   = WB;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    ebp_rw_d  = WR_CODE;
                    esp_rw_d  = WR_CODE;
                    done_d    = 1'b1;
                    if (op_q == OP_ENTER) begin
                        ebp_wdata_d = esp_q - STEP;
                        esp_wdata_d = esp_q - STEP;
                    end else begin
                        ebp_wdata_d = bus.mem_rdata;
                        esp_wdata_d = ebp_q + STEP;
                    end
                end else begin
                    // The counter records how many cycles mem_req has already been up unanswered.
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(TIMEOUT)) begin
                        state_d   = ERR;
                        mem_req_d = 1'b0;
                        mem_we_d  = 1'b0;
                        err_d     = 1'b1;
                    end
                end
            end
            WB, ERR: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= 2'b00;
            ebp_q       <= '0;
            esp_q       <= '0;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ebp_rw_q    <= 4'h0;
            esp_rw_q    <= 4'h0;
            ebp_wdata_q <= '0;
            esp_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            ebp_q       <= ebp_d;
            esp_q       <= esp_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ebp_rw_q    <= ebp_rw_d;
            esp_rw_q    <= esp_rw_d;
            ebp_wdata_q <= ebp_wdata_d;
            esp_wdata_q <= esp_wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.ebp_rw    = ebp_rw_q;
    assign bus.esp_rw    = esp_rw_q;
    assign bus.ebp_wdata = ebp_wdata_q;
    assign bus.esp_wdata = esp_wdata_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_frame_op_sequencer.sv
// Bench for frame_op_sequencer: directed ENTER/LEAVE/error/reset cases followed by random
// operations, each checked against a register-and-stack-memory model of the frame operations.
module tb_frame_op_sequencer;
    localparam int         TIMEOUT = 15;
    localparam logic [1:0] ENTER   = 2'b01;
    localparam logic [1:0] LEAVE   = 2'b10;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    frame_op_sequencer_if #(.DATA_W(32)) bus ();

    frame_op_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int assertCount = 0;
    int failCount   = 0;

    // Model state: the architectural ebp/esp and the stack memory contents.
    logic [31:0] stackMem [logic [31:0]];
    logic [31:0] regEbp;
    logic [31:0] regEsp;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [1:0] op,
                                 input logic [31:0] ebp, input logic [31:0] esp);
        bus.cmd_valid = valid;
        bus.cmd_op    = op;
        bus.ebp_in    = ebp;
        bus.esp_in    = esp;
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_ready"},  32'(bus.cmd_ready), 32'd1);
        checkOutput({tag, "_memreq"}, 32'(bus.mem_req),   32'd0);
        checkOutput({tag, "_ebprw"},  32'(bus.ebp_rw),    32'd0);
        checkOutput({tag, "_esprw"},  32'(bus.esp_rw),    32'd0);
        checkOutput({tag, "_done"},   32'(bus.done),      32'd0);
        checkOutput({tag, "_err"},    32'(bus.err),       32'd0);
    endtask

    // One complete operation; ackDelay >= TIMEOUT means memory never answers.
    task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] ebp,
                         input logic [31:0] esp, input int ackDelay);
        logic        legal;
        logic [31:0] expAddr;
        logic [31:0] expEbp;
        logic [31:0] expEsp;
        legal   = (op == ENTER) || (op == LEAVE);
        expAddr = (op == ENTER) ? esp - 32'd4 : ebp;
        expEbp  = 32'd0;
        expEsp  = 32'd0;

        checkOutput({tag, "_ready_pre"}, 32'(bus.cmd_ready), 32'd1);
        applyStimulus(1'b1, op, ebp, esp);
        step();
        applyStimulus(1'b0, 2'($urandom), $urandom, $urandom);

        if (!legal) begin
            checkOutput({tag, "_err"},    32'(bus.err),       32'd1);
            checkOutput({tag, "_memreq"}, 32'(bus.mem_req),   32'd0);
            checkOutput({tag, "_ebprw"},  32'(bus.ebp_rw),    32'd0);
            checkOutput({tag, "_esprw"},  32'(bus.esp_rw),    32'd0);
            checkOutput({tag, "_ready"},  32'(bus.cmd_ready), 32'd0);
            step();
            checkQuiet({tag, "_after"});
            return;
        end

        if (op == ENTER) begin
            expEbp = esp - 32'd4;
            expEsp = esp - 32'd4;
        end else begin
            if (!stackMem.exists(ebp)) stackMem[ebp] = $urandom;
            expEbp = stackMem[ebp];
            expEsp = ebp + 32'd4;
        end

        for (int w = 0; w < TIMEOUT; w++) begin
            checkOutput({tag, "_memreq"}, 32'(bus.mem_req),   32'd1);
            checkOutput({tag, "_we"},     32'(bus.mem_we),    32'(op == ENTER));
            checkOutput({tag, "_addr"},   bus.mem_addr,       expAddr);
            if (op == ENTER) checkOutput({tag, "_mwdata"}, bus.mem_wdata, ebp);
            checkOutput({tag, "_rw_mem"}, 32'(bus.ebp_rw | bus.esp_rw), 32'd0);
            checkOutput({tag, "_flags"},  32'({bus.done, bus.err, bus.cmd_ready}), 32'd0);
            if (w == ackDelay) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = (op == LEAVE) ? stackMem[ebp] : $urandom;
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = $urandom;
            end
            step();
            bus.mem_ack = 1'b0;
            if (w == ackDelay) break;
        end

        if (ackDelay >= TIMEOUT) begin
            checkOutput({tag, "_to_err"},    32'(bus.err),     32'd1);
            checkOutput({tag, "_to_memreq"}, 32'(bus.mem_req), 32'd0);
            checkOutput({tag, "_to_rw"},     32'(bus.ebp_rw | bus.esp_rw), 32'd0);
            checkOutput({tag, "_to_done"},   32'(bus.done),    32'd0);
            step();
            checkQuiet({tag, "_to_after"});
            return;
        end

        if (op == ENTER) stackMem[esp - 32'd4] = ebp;
        checkOutput({tag, "_ebprw"},   32'(bus.ebp_rw),    32'h2);
        checkOutput({tag, "_esprw"},   32'(bus.esp_rw),    32'h2);
        checkOutput({tag, "_ebpdata"}, bus.ebp_wdata,      expEbp);
        checkOutput({tag, "_espdata"}, bus.esp_wdata,      expEsp);
        checkOutput({tag, "_done"},    32'(bus.done),      32'd1);
        checkOutput({tag, "_wb_misc"}, 32'({bus.mem_req, bus.err, bus.cmd_ready}), 32'd0);
        regEbp = expEbp;
        regEsp = expEsp;
        step();
        checkQuiet({tag, "_after"});
    endtask

    initial begin
        logic        sawPulse;
        logic [1:0]  op;
        int          r;

        applyStimulus(1'b0, 2'b00, 32'd0, 32'd0);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
        reset = 1'b1;
        repeat (3) step();
        checkQuiet("reset");
        checkOutput("reset_wdata", bus.ebp_wdata | bus.esp_wdata | bus.mem_addr, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checkQuiet("idle");
        end

        runOp("enter_basic", ENTER, 32'h0000_0999, 32'h0000_1000, 0);
        runOp("leave_wait3", LEAVE, 32'h0000_0FFC, 32'h0000_0FFC, 3);
        checkOutput("model_after_leave", regEsp, 32'h0000_1000);
        runOp("enter_wrap", ENTER, 32'h1234_5678, 32'h0000_0000, 1);
        runOp("leave_wrap", LEAVE, 32'hFFFF_FFFC, 32'h0000_0000, 0);
        runOp("illegal_11", 2'b11, 32'h0000_0040, 32'h0000_0080, 0);
        runOp("illegal_00", 2'b00, 32'h0000_0040, 32'h0000_0080, 0);
        runOp("timeout", ENTER, 32'h0000_2000, 32'h0000_3000, TIMEOUT);

        // Reset while the ENTER is waiting on memory must abandon it silently.
        applyStimulus(1'b1, ENTER, 32'h0000_0100, 32'h0000_0200);
        step();
        applyStimulus(1'b0, 2'b00, 32'd0, 32'd0);
        checkOutput("rstmid_memreq_pre", 32'(bus.mem_req), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkQuiet("rstmid");
        sawPulse = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            sawPulse = sawPulse | bus.done | bus.err;
        end
        checkOutput("rstmid_no_pulse", 32'(sawPulse), 32'd0);

        regEbp = 32'h0001_0000;
        regEsp = 32'h0000_F000;
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5)      op = ENTER;
            else if (r < 9) op = LEAVE;
            else            op = (r[0]) ? 2'b11 : 2'b00;
            if ($urandom_range(0, 7) == 0) regEsp = $urandom & 32'hFFFF_FFFC;
            runOp("random", op, regEbp, regEsp, $urandom_range(0, 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
